trans_demux_wrap_ipa: RTL and testbench

Command demultiplexer for the MCHAN IPA control unit: accepts the single arbitrated transfer-command stream (fields plus core id `cid_i`) and routes each command back out to one of NB_CORES per-core command ports. Each output port has its own small FIFO, so a stalled core does not block commands for other cores once they are buffered. The block sits downstream of the transfer arbiter on the response/dispatch side of the control unit.

---
 rtl/mchan_ipa_pkg.sv | 33 +++
 rtl/trans_fifo_ipa.sv | 62 ++++++
 rtl/trans_demux_wrap_ipa.sv | 99 +++++++++
 tb/tb_trans_demux_wrap_ipa.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mchan_ipa_pkg.sv
// Shared MCHAN IPA command definitions: field order of the packed command word
// (MSB->LSB: sid, twd_add, ble, ile, ele, twd, inc, opc, len, tcdm_add, ext_add).
package mchan_ipa_pkg;

  localparam int unsigned CMD_FLAG_NUM = 5;

  // Default-configuration view of the packed command word.
  typedef struct packed {
    logic [0:0]  sid;
    logic [0:0]  twd_add;
    logic        ble;
    logic        ile;
    logic        ele;
    logic        twd;
    logic        inc;
    logic [0:0]  opc;
    logic [4:0]  len;
    logic [15:0] tcdm_add;
    logic [31:0] ext_add;
  } mchan_cmd_t;

  function automatic int unsigned cmd_pkt_width(
    input int unsigned len_w,
    input int unsigned tcdm_w,
    input int unsigned ext_w,
    input int unsigned opc_w,
    input int unsigned twd_add_w,
    input int unsigned sid_w
  );
    return sid_w + twd_add_w + CMD_FLAG_NUM + opc_w + len_w + tcdm_w + ext_w;
  endfunction

endpackage

// File: rtl/trans_fifo_ipa.sv
// Synchronous FIFO with registered occupancy count; storage is not reset.
module trans_fifo_ipa
  import mchan_ipa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/trans_demux_wrap_ipa.sv
// Routes the arbitrated transfer-command stream to per-core command ports,
// each buffered by its own FIFO.
module trans_demux_wrap_ipa
  import mchan_ipa_pkg::*;
#(
  parameter int NB_CORES            = 2,
  parameter int MCHAN_LEN_WIDTH     = 5,
  parameter int TCDM_ADD_WIDTH      = 16,
  parameter int EXT_ADD_WIDTH       = 32,
  parameter int MCHAN_OPC_WIDTH     = 1,
  parameter int TWD_QUEUE_ADD_WIDTH = 1,
  parameter int TRANS_SID_WIDTH     = 1,
  parameter int TRANS_CID_WIDTH     = $clog2(NB_CORES),
  parameter int FIFO_DEPTH          = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_i,
  output logic                           gnt_o,
  input  logic [TRANS_CID_WIDTH-1:0]     cid_i,
  input  logic [EXT_ADD_WIDTH-1:0]       ext_add_i,
  input  logic [TCDM_ADD_WIDTH-1:0]      tcdm_add_i,
  input  logic [MCHAN_LEN_WIDTH-1:0]     len_i,
  input  logic [MCHAN_OPC_WIDTH-1:0]     opc_i,
  input  logic [TWD_QUEUE_ADD_WIDTH-1:0] twd_add_i,
  input  logic [TRANS_SID_WIDTH-1:0]     sid_i,
  input  logic                           inc_i,
  input  logic                           twd_i,
  input  logic                           ele_i,
  input  logic                           ile_i,
  input  logic                           ble_i,
  output logic [NB_CORES-1:0]            req_o,
  input  logic [NB_CORES-1:0]            gnt_i,
  output logic [EXT_ADD_WIDTH-1:0]       ext_add_o  [NB_CORES],
  output logic [TCDM_ADD_WIDTH-1:0]      tcdm_add_o [NB_CORES],
  output logic [MCHAN_LEN_WIDTH-1:0]     len_o      [NB_CORES],
  output logic [MCHAN_OPC_WIDTH-1:0]     opc_o      [NB_CORES],
  output logic [TWD_QUEUE_ADD_WIDTH-1:0] twd_add_o  [NB_CORES],
  output logic [TRANS_SID_WIDTH-1:0]     sid_o      [NB_CORES],
  output logic                           inc_o      [NB_CORES],
  output logic                           twd_o      [NB_CORES],
  output logic                           ele_o      [NB_CORES],
  output logic                           ile_o      [NB_CORES],
  output logic                           ble_o      [NB_CORES],
  output logic                           err_o
);

  localparam int unsigned PKT_WIDTH = cmd_pkt_width(MCHAN_LEN_WIDTH, TCDM_ADD_WIDTH, EXT_ADD_WIDTH,
                                                    MCHAN_OPC_WIDTH, TWD_QUEUE_ADD_WIDTH, TRANS_SID_WIDTH);

  logic [PKT_WIDTH-1:0] pkt_in;
  logic [PKT_WIDTH-1:0] pkt_out [NB_CORES];
  logic [NB_CORES-1:0]  sel, full, empty, push;
  logic                 cid_valid, full_sel;
  logic                 err_q, err_d;

  assign pkt_in = {sid_i, twd_add_i, ble_i, ile_i, ele_i, twd_i, inc_i, opc_i, len_i, tcdm_add_i, ext_add_i};

  // An out-of-range cid decodes to no select bit; it is granted and dropped.
  always_comb begin
    sel = '0;
    for (int unsigned k = 0; k < NB_CORES; k++) begin
      sel[k] = (cid_i == TRANS_CID_WIDTH'(k));
    end
    cid_valid = |sel;
    full_sel  = |(full & sel);
    gnt_o     = req_i & (~cid_valid | ~full_sel);
    push      = sel & {NB_CORES{req_i & gnt_o}};
    err_d     = req_i & ~cid_valid;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;

  for (genvar k = 0; k < NB_CORES; k++) begin : g_core
    trans_fifo_ipa #(
      .DATA_WIDTH(PKT_WIDTH),
      .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (push[k]),
      .pop_i  (gnt_i[k]),
      .data_i (pkt_in),
      .data_o (pkt_out[k]),
      .full_o (full[k]),
      .empty_o(empty[k])
    );

    assign req_o[k] = ~empty[k];
    assign {sid_o[k], twd_add_o[k], ble_o[k], ile_o[k], ele_o[k], twd_o[k], inc_o[k],
            opc_o[k], len_o[k], tcdm_add_o[k], ext_add_o[k]} = pkt_out[k];
  end

endmodule

// File: tb/tb_trans_demux_wrap_ipa.sv
// Directed bench for trans_demux_wrap_ipa: a 2-core instance for routing,
// back-pressure and reset, and a 3-core instance for out-of-range cid drops.
module tb_trans_demux_wrap_ipa;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // shared command fields
  logic [15:0] tcdm_add;
  logic [4:0]  len;
  logic [0:0]  opc, twd_add, sid;
  logic        inc, twd, ele, ile, ble;

  // 2-core instance
  logic        req, gnt;
  logic [0:0]  cid;
  logic [31:0] ext_add;
  logic [1:0]  req_o, gnt_i;
  logic        err;
  logic [31:0] ext_add_o  [2];
  logic [15:0] tcdm_add_o [2];
  logic [4:0]  len_o      [2];
  logic [0:0]  opc_o [2], twd_add_o [2], sid_o [2];
  logic        inc_o [2], twd_o [2], ele_o [2], ile_o [2], ble_o [2];

  // 3-core instance
  logic        req3, gnt3;
  logic [1:0]  cid3;
  logic [31:0] ext_add3;
  logic [2:0]  req_o3, gnt_i3;
  logic        err3;
  logic [31:0] ext_add_o3  [3];
  logic [15:0] tcdm_add_o3 [3];
  logic [4:0]  len_o3      [3];
  logic [0:0]  opc_o3 [3], twd_add_o3 [3], sid_o3 [3];
  logic        inc_o3 [3], twd_o3 [3], ele_o3 [3], ile_o3 [3], ble_o3 [3];

  trans_demux_wrap_ipa #(.NB_CORES(2), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .cid_i(cid),
    .ext_add_i(ext_add), .tcdm_add_i(tcdm_add), .len_i(len), .opc_i(opc),
    .twd_add_i(twd_add), .sid_i(sid), .inc_i(inc), .twd_i(twd), .ele_i(ele),
    .ile_i(ile), .ble_i(ble), .req_o(req_o), .gnt_i(gnt_i),
    .ext_add_o(ext_add_o), .tcdm_add_o(tcdm_add_o), .len_o(len_o), .opc_o(opc_o),
    .twd_add_o(twd_add_o), .sid_o(sid_o), .inc_o(inc_o), .twd_o(twd_o),
    .ele_o(ele_o), .ile_o(ile_o), .ble_o(ble_o), .err_o(err)
  );

  trans_demux_wrap_ipa #(.NB_CORES(3), .FIFO_DEPTH(2)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .gnt_o(gnt3), .cid_i(cid3),
    .ext_add_i(ext_add3), .tcdm_add_i(tcdm_add), .len_i(len), .opc_i(opc),
    .twd_add_i(twd_add), .sid_i(sid), .inc_i(inc), .twd_i(twd), .ele_i(ele),
    .ile_i(ile), .ble_i(ble), .req_o(req_o3), .gnt_i(gnt_i3),
    .ext_add_o(ext_add_o3), .tcdm_add_o(tcdm_add_o3), .len_o(len_o3), .opc_o(opc_o3),
    .twd_add_o(twd_add_o3), .sid_o(sid_o3), .inc_o(inc_o3), .twd_o(twd_o3),
    .ele_o(ele_o3), .ile_o(ile_o3), .ble_o(ble_o3), .err_o(err3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b0; cid = '0; ext_add = '0; gnt_i = '0;
    req3 = 1'b0; cid3 = '0; ext_add3 = '0; gnt_i3 = '0;
    tcdm_add = 16'h1234; len = 5'd0; opc = 1'b1; twd_add = 1'b0; sid = 1'b1;
    inc = 1'b1; twd = 1'b0; ele = 1'b1; ile = 1'b0; ble = 1'b1;

    // reset and idle
    repeat (2) step;
    check("rst_req_o", 64'(req_o), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_gnt", 64'(gnt), 64'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step;
      check("idle_req_o", 64'(req_o), 64'h0);
      check("idle_gnt", 64'(gnt), 64'h0);
      check("idle_err", 64'(err), 64'h0);
    end

    // single command to core 1
    gnt_i = 2'b11; req = 1'b1; cid = 1'b1; ext_add = 32'hDEAD_BEEF; len = 5'd7;
    #1 check("single_gnt", 64'(gnt), 64'h1);
    step;
    req = 1'b0;
    check("single_req_o", 64'(req_o), 64'h2);
    check("single_ext", 64'(ext_add_o[1]), 64'hDEAD_BEEF);
    check("single_len", 64'(len_o[1]), 64'h7);
    check("single_tcdm", 64'(tcdm_add_o[1]), 64'h1234);
    check("single_flags", 64'({sid_o[1], twd_add_o[1], ble_o[1], ile_o[1], ele_o[1], twd_o[1], inc_o[1], opc_o[1]}), 64'hAB);
    check("single_err", 64'(err), 64'h0);
    step;
    check("single_drain", 64'(req_o), 64'h0);

    // back-to-back to stalled core 0
    gnt_i = 2'b00; req = 1'b1; cid = 1'b0; ext_add = 32'd1;
    #1 check("b2b_gnt1", 64'(gnt), 64'h1);
    step;
    ext_add = 32'd2;
    #1 check("b2b_gnt2", 64'(gnt), 64'h1);
    step;
    ext_add = 32'd3;
    #1 check("b2b_gnt3_full", 64'(gnt), 64'h0);
    check("b2b_req_o", 64'(req_o), 64'h1);
    check("b2b_head", 64'(ext_add_o[0]), 64'h1);

    // core 0 full and stalled, command to core 1 still flows
    cid = 1'b1; ext_add = 32'h55;
    #1 check("other_gnt", 64'(gnt), 64'h1);
    step;
    req = 1'b0;
    check("other_req_o", 64'(req_o), 64'h3);
    check("other_ext1", 64'(ext_add_o[1]), 64'h55);
    check("other_head0", 64'(ext_add_o[0]), 64'h1);
    gnt_i = 2'b10;
    step;
    check("other_pop_req_o", 64'(req_o), 64'h1);
    check("other_hold0", 64'(ext_add_o[0]), 64'h1);

    // full core popped same cycle: no grant
    req = 1'b1; cid = 1'b0; ext_add = 32'd3; gnt_i = 2'b01;
    #1 check("nobypass_gnt", 64'(gnt), 64'h0);
    step;
    gnt_i = 2'b00;
    #1 check("after_pop_gnt", 64'(gnt), 64'h1);
    check("after_pop_head", 64'(ext_add_o[0]), 64'h2);
    step;
    req = 1'b0; gnt_i = 2'b01;
    check("order_head2", 64'(ext_add_o[0]), 64'h2);
    check("order_req_o", 64'(req_o), 64'h1);
    step;
    check("order_head3", 64'(ext_add_o[0]), 64'h3);
    check("order_req_o3", 64'(req_o), 64'h1);
    step;
    check("order_drain", 64'(req_o), 64'h0);

    // reset with both FIFOs holding entries
    gnt_i = 2'b00; req = 1'b1; cid = 1'b0; ext_add = 32'hA;
    step;
    cid = 1'b1; ext_add = 32'hB;
    step;
    req = 1'b0;
    check("prerst_req_o", 64'(req_o), 64'h3);
    rst_n = 1'b0;
    #1 check("midrst_req_o", 64'(req_o), 64'h0);
    check("midrst_err", 64'(err), 64'h0);
    step;
    rst_n = 1'b1;
    step;
    check("postrst_req_o", 64'(req_o), 64'h0);
    step;
    check("postrst_req_o2", 64'(req_o), 64'h0);
    req = 1'b1; cid = 1'b0; ext_add = 32'hC;
    step;
    req = 1'b0;
    check("postrst_new_req_o", 64'(req_o), 64'h1);
    check("postrst_new_head", 64'(ext_add_o[0]), 64'hC);

    // 3-core instance: out-of-range cid is granted, dropped, flagged
    gnt_i3 = 3'b111; req3 = 1'b1; cid3 = 2'd3; ext_add3 = 32'h99;
    #1 check("oor_gnt", 64'(gnt3), 64'h1);
    check("oor_err_pre", 64'(err3), 64'h0);
    step;
    req3 = 1'b0;
    check("oor_err", 64'(err3), 64'h1);
    check("oor_req_o", 64'(req_o3), 64'h0);
    step;
    check("oor_err_clr", 64'(err3), 64'h0);
    gnt_i3 = 3'b000; req3 = 1'b1; cid3 = 2'd2; ext_add3 = 32'h77;
    #1 check("c2_gnt", 64'(gnt3), 64'h1);
    step;
    req3 = 1'b0;
    check("c2_req_o", 64'(req_o3), 64'h4);
    check("c2_ext", 64'(ext_add_o3[2]), 64'h77);
    check("c2_err", 64'(err3), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
